register_file: RTL and testbench

//  Architectural GPR file; the receiving end of the write-back port (writeEnable/regDst/writeValue).

---
 rtl/register_file.sv | 74 +++++++
 tb/tb_register_file.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: GPR file with two combinational read ports and a halt-triggered valid/ready register dump.
// Define REGFILE_BYPASS_EN to forward a same-cycle write-back onto matching read ports.
module register_file #(
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W = 5,
    parameter int SP_INDEX = 29,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_2FFC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] regDst,
    input  logic [DATA_W-1:0] writeValue,
    input  logic [ADDR_W-1:0] readId1,
    input  logic [ADDR_W-1:0] readId2,
    output logic [DATA_W-1:0] readValue1,
    output logic [DATA_W-1:0] readValue2,
    input  logic              halt,
    input  logic              dumpReady,
    output logic              dumpValid,
    output logic [ADDR_W-1:0] dumpIndex,
    output logic [DATA_W-1:0] dumpValue,
    output logic              dumpDone
);
    typedef enum logic [1:0] {RUN, DUMP, DONE} state_t;

    state_t state, state_nx;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic wr, last;

    assign wr = state == RUN && writeEnable && regDst != '0;
    assign last = cnt == ADDR_W'(NUM_REGS - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            state <= RUN;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (wr)
                regs[regDst] <= writeValue;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        if (state == RUN && halt)
            state_nx = DUMP;
        if (state == DUMP && dumpReady) begin
            cnt_nx = last ? '0 : cnt + 1'b1;
            state_nx = last ? DONE : DUMP;
        end
    end

    assign dumpValid = state == DUMP;
    assign dumpIndex = dumpValid ? cnt : '0;
    assign dumpValue = dumpValid ? regs[cnt] : '0;
    assign dumpDone = state == DONE;

`ifdef REGFILE_BYPASS_EN
    // wr already excludes index 0 and non-RUN states, so forwarding cannot break either rule
    assign readValue1 = readId1 == '0 ? '0 : (wr && regDst == readId1) ? writeValue : regs[readId1];
    assign readValue2 = readId2 == '0 ? '0 : (wr && regDst == readId2) ? writeValue : regs[readId2];
`else
    assign readValue1 = readId1 == '0 ? '0 : regs[readId1];
    assign readValue2 = readId2 == '0 ? '0 : regs[readId2];
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: random and directed stimulus against an array-based model of the register file.
module tb_register_file;
    logic clock = 0, reset = 0;
    logic writeEnable = 0, halt = 0, dumpReady = 0;
    logic [4:0] regDst = 0, readId1 = 0, readId2 = 0, dumpIndex;
    logic [31:0] writeValue = 0, readValue1, readValue2, dumpValue;
    logic dumpValid, dumpDone;

    int tests = 0, fails = 0;
    bit chk = 0;
    logic [31:0] m [32];
    int mode = 0, beat = 0;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1;
`else
    localparam bit BYP = 0;
`endif

    register_file dut (
        .clock(clock), .reset(reset), .writeEnable(writeEnable), .regDst(regDst),
        .writeValue(writeValue), .readId1(readId1), .readId2(readId2),
        .readValue1(readValue1), .readValue2(readValue2), .halt(halt),
        .dumpReady(dumpReady), .dumpValid(dumpValid), .dumpIndex(dumpIndex),
        .dumpValue(dumpValue), .dumpDone(dumpDone)
    );

    always #5 clock = ~clock;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // mode: 0 running, 1 dumping, 2 dump finished
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m[i] <= (i == 29) ? 32'h2FFC : 32'h0;
            mode <= 0;
            beat <= 0;
        end else if (mode == 0) begin
            if (writeEnable && regDst != 0) m[regDst] <= writeValue;
            if (halt) mode <= 1;
        end else if (mode == 1 && dumpReady) begin
            mode <= (beat == 31) ? 2 : 1;
            beat <= (beat == 31) ? 0 : beat + 1;
        end
    end

    function automatic logic [31:0] exp_read(logic [4:0] id);
        if (id == 0) return 0;
        if (BYP && mode == 0 && writeEnable && regDst == id) return writeValue;
        return m[id];
    endfunction

    always @(negedge clock) if (chk) begin
        check("readValue1", readValue1, exp_read(readId1));
        check("readValue2", readValue2, exp_read(readId2));
        check("dumpValid", 32'(dumpValid), 32'(mode == 1));
        check("dumpIndex", 32'(dumpIndex), mode == 1 ? 32'(beat) : 0);
        check("dumpValue", dumpValue, mode == 1 ? m[beat] : 0);
        check("dumpDone", 32'(dumpDone), 32'(mode == 2));
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1;
        #1;
        check("rst_valid", 32'(dumpValid), 0);
        check("rst_done", 32'(dumpDone), 0);
        tick;
        reset = 0;
        halt = 0;
        writeEnable = 0;
    endtask

    task automatic rand_run(int n);
        repeat (n) begin
            writeEnable = 1'($urandom_range(0, 1));
            regDst = 5'($urandom);
            writeValue = $urandom;
            readId1 = 5'($urandom);
            readId2 = ($urandom_range(0, 3) == 0) ? regDst : 5'($urandom);
            tick;
        end
        writeEnable = 0;
    endtask

    initial begin
        logic [4:0] idx_q[$];
        logic [31:0] val_q[$];
        int n;
        bit tog;
        #1 reset = 1;
        tick;
        tick;
        reset = 0;
        chk = 1;
        readId1 = 8;
        readId2 = 29;
        #1;
        check("reset_sp", readValue2, 32'h2FFC);
        check("reset_r8", readValue1, 0);
        // write then read next cycle
        writeEnable = 1; regDst = 8; writeValue = 32'h1234;
        tick;
        writeEnable = 0;
        #1 check("t1_r8", readValue1, 32'h1234);
        // writes to r0 are discarded
        writeEnable = 1; regDst = 0; writeValue = 32'hFFFF_FFFF; readId1 = 0;
        #1 check("t2_before", readValue1, 0);
        tick;
        writeEnable = 0;
        #1 check("t2_after", readValue1, 0);
        // same-cycle write/read
        writeEnable = 1; regDst = 5; writeValue = 32'hABCD; readId2 = 5;
        #1 check("t3_same", readValue2, BYP ? 32'hABCD : 32'h0);
        tick;
        writeEnable = 0;
        #1 check("t3_next", readValue2, 32'hABCD);
        rand_run(300);
        // reset in the middle of a dump
        do_reset;
        halt = 1; dumpReady = 1;
        tick;
        halt = 0;
        n = 0;
        while (dumpIndex != 10 && n < 50) begin tick; n++; end
        check("t5_reach10", 32'(dumpIndex), 10);
        #2 reset = 1;
        #1;
        check("t5_valid", 32'(dumpValid), 0);
        check("t5_done", 32'(dumpDone), 0);
        tick;
        reset = 0; dumpReady = 0;
        writeEnable = 1; regDst = 4; writeValue = 9; readId1 = 4;
        tick;
        writeEnable = 0;
        #1 check("t5_r4", readValue1, 9);
        rand_run(200);
        // halt with same-cycle write, toggling ready
        do_reset;
        writeEnable = 1; regDst = 3; writeValue = 7; halt = 1; dumpReady = 0;
        tick;
        writeEnable = 0; halt = 0;
        tog = 1; n = 0;
        while (!dumpDone && n < 200) begin
            dumpReady = tog;
            #1;
            if (dumpValid && dumpReady) begin idx_q.push_back(dumpIndex); val_q.push_back(dumpValue); end
            tog = !tog;
            tick;
            n++;
        end
        check("t4_done", 32'(dumpDone), 1);
        check("t4_beats", 32'(idx_q.size()), 32);
        for (int i = 0; i < idx_q.size(); i++)
            if (idx_q[i] != 5'(i)) check("t4_order", 32'(idx_q[i]), 32'(i));
        if (val_q.size() == 32) begin
            check("t4_beat3", val_q[3], 7);
            check("t4_beat29", val_q[29], 32'h2FFC);
        end
        writeEnable = 1; regDst = 3; writeValue = 32'h99; readId1 = 3; halt = 1;
        tick;
        writeEnable = 0; halt = 0;
        #1 check("t4_frozen", readValue1, 7);
        check("t4_sticky", 32'(dumpDone), 1);
        // constant ready: done 32 edges after DUMP entry
        do_reset;
        halt = 1; dumpReady = 1;
        tick;
        halt = 0;
        n = 0;
        while (!dumpDone && n < 100) begin tick; n++; end
        check("t6_edges", 32'(n), 32);
        // random traffic then a dump with random ready
        do_reset;
        rand_run(150);
        halt = 1;
        tick;
        halt = 0;
        n = 0;
        while (!dumpDone && n < 600) begin dumpReady = 1'($urandom_range(0, 1)); tick; n++; end
        check("rand_dump_done", 32'(dumpDone), 1);
        rand_run(20);
        chk = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
